// File: rtl/mem_responder.sv
// mem_responder: single-port word memory that serves one request at a time
// from either an instruction-fetch port (ifu) or a load/store port (lsu).
//
// Handshake: a request is level-sampled and is accepted on any rising edge
// where the FSM is IDLE and the port's reqValid is high (lsu wins if both are
// high). Accepting is the only form of "ready"; reqValid is ignored outside
// IDLE. The served port's respValid pulses for exactly one cycle, LATENCY
// cycles after the accept cycle, and its rdata is valid from that cycle until
// that port's next response.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   ifu_reqValid/addr     fetch request (addr[1:0] ignored)
//   ifu_respValid/rdata   fetch response pulse and fetched word
//   lsu_reqValid/addr     load/store request
//   lsu_wen/size/wdata    1 = store; 0 byte, 1 half, 2/3 word; right-aligned data
//   lsu_respValid/rdata   load/store response pulse and zero-extended load data
//   busy                  high whenever the FSM is not IDLE
//   state_dbg             current FSM state encoding (IDLE=0, WAIT=1, RESP=2)
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [1:0]  lsu_size,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int AB = AW + 2;  // byte-address bits that matter

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        commit;

  // Captured transaction
  logic          port_lsu_q;
  logic [AB-1:0] addr_q;
  logic [1:0]    size_q;
  logic          wen_q;
  logic [31:0]   wdata_q;

  // Transaction currently being worked on: live inputs while IDLE (needed
  // when LATENCY = 1 commits on the accepting edge), captured copy otherwise.
  logic          cur_lsu;
  logic [AB-1:0] cur_addr;
  logic [1:0]    cur_size;
  logic          cur_wen;
  logic [31:0]   cur_wdata;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   ld;

  logic accept;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{ifu_addr[31:AB], lsu_addr[31:AB]};

  assign accept = (state == IDLE) && (lsu_reqValid || ifu_reqValid);

  always_comb begin
    cur_lsu   = port_lsu_q;
    cur_addr  = addr_q;
    cur_size  = size_q;
    cur_wen   = wen_q;
    cur_wdata = wdata_q;
    if (state == IDLE) begin
      cur_lsu = lsu_reqValid;
      if (lsu_reqValid) begin
        cur_addr  = lsu_addr[AB-1:0];
        cur_size  = lsu_size;
        cur_wen   = lsu_wen;
        cur_wdata = lsu_wdata;
      end else begin
        cur_addr  = ifu_addr[AB-1:0];
        cur_size  = 2'd2;
        cur_wen   = 1'b0;
        cur_wdata = 32'h0;
      end
    end
  end

  // Next-state logic; commit marks the edge entering RESP.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
            cnt_nxt   = 4'd0;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          cnt_nxt   = 4'd0;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane selection shared by loads and stores.
  assign idx     = cur_addr[AB-1:2];
  assign rd_word = mem[idx];

  always_comb begin
    be = 4'b1111;
    wd = cur_wdata;
    ld = rd_word;
    case (cur_size)
      2'd0: begin
        be = 4'b0001 << cur_addr[1:0];
        wd = {4{cur_wdata[7:0]}};
        ld = (rd_word >> {cur_addr[1:0], 3'b000}) & 32'h0000_00FF;
      end
      2'd1: begin
        be = cur_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{cur_wdata[15:0]}};
        ld = (rd_word >> {cur_addr[1], 4'b0000}) & 32'h0000_FFFF;
      end
      default: begin
        be = 4'b1111;
        wd = cur_wdata;
        ld = rd_word;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      port_lsu_q <= 1'b0;
      addr_q     <= '0;
      size_q     <= 2'd0;
      wen_q      <= 1'b0;
      wdata_q    <= 32'h0;
      ifu_rdata  <= 32'h0;
      lsu_rdata  <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        port_lsu_q <= cur_lsu;
        addr_q     <= cur_addr;
        size_q     <= cur_size;
        wen_q      <= cur_wen;
        wdata_q    <= cur_wdata;
      end
      if (commit && !cur_wen) begin
        if (cur_lsu) lsu_rdata <= ld;
        else         ifu_rdata <= rd_word;
      end
    end
  end

  // Array is deliberately not reset. An aborted transaction never reaches
  // commit because reset pulls the FSM back to IDLE first.
  always_ff @(posedge clock) begin
    if (commit && cur_wen) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  assign ifu_respValid = (state == RESP) && !port_lsu_q;
  assign lsu_respValid = (state == RESP) && port_lsu_q;
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: table of single transactions followed by
// hand-written multi-cycle sequences (arbitration, held request, reset abort).
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_wdata;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        busy;
  logic [1:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] last_lsu = 32'h0;

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
    .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata),
    .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
    .lsu_size(lsu_size), .lsu_wdata(lsu_wdata),
    .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata),
    .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_lsu;
    logic        wen;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;   // load/fetch result
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete transaction; inputs change on the falling edge.
  task automatic run_txn(input vec_t v, input int i);
    int lat;
    bit seen;
    logic [31:0] exp_d;
    @(negedge clock);
    lsu_reqValid = v.is_lsu;
    ifu_reqValid = !v.is_lsu;
    lsu_addr     = v.addr;
    ifu_addr     = v.addr;
    lsu_wen      = v.wen;
    lsu_size     = v.size;
    lsu_wdata    = v.wdata;
    @(negedge clock);
    lsu_reqValid = 1'b0;
    ifu_reqValid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= 20) begin
      if (ifu_respValid || lsu_respValid) seen = 1'b1;
      else begin
        @(negedge clock);
        lat++;
      end
    end
    check($sformatf("v%0d latency", i), lat, LAT);
    check($sformatf("v%0d resp port", i), {lsu_respValid, ifu_respValid}, {v.is_lsu, !v.is_lsu});
    if (v.is_lsu) begin
      exp_d = v.wen ? last_lsu : v.exp;
      check($sformatf("v%0d lsu_rdata", i), lsu_rdata, exp_d);
      last_lsu = exp_d;
    end else begin
      check($sformatf("v%0d ifu_rdata", i), ifu_rdata, v.exp);
    end
    @(negedge clock);
    check($sformatf("v%0d pulse end", i), {lsu_respValid, ifu_respValid, busy}, 3'b000);
  endtask

  initial begin
    int pulses;
    //          lsu   wen   size   addr          wdata         exp
    vecs[0]  = '{1'b1, 1'b1, 2'd2, 32'h0000_0000, 32'h1234_5678, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0000, 32'h0,         32'h1234_5678};
    vecs[2]  = '{1'b1, 1'b1, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0013, 32'h0,         32'h0000_00DE};
    vecs[4]  = '{1'b1, 1'b0, 2'd1, 32'h0000_0012, 32'h0,         32'h0000_DEAD};
    vecs[5]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0010, 32'h0,         32'h0000_00EF};
    vecs[6]  = '{1'b1, 1'b1, 2'd2, 32'h0000_0010, 32'h1122_3344, 32'h0};
    vecs[7]  = '{1'b1, 1'b1, 2'd0, 32'h0000_0011, 32'h0000_00AA, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0010, 32'h0,         32'h1122_AA44};
    vecs[9]  = '{1'b1, 1'b1, 2'd1, 32'h0000_0012, 32'hCAFE_BABE, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 2'd2, 32'h0000_0011, 32'h0,         32'hBABE_AA44};
    vecs[11] = '{1'b1, 1'b0, 2'd1, 32'h0000_0011, 32'h0,         32'h0000_AA44};
    vecs[12] = '{1'b0, 1'b0, 2'd2, 32'h0000_0012, 32'h0,         32'hBABE_AA44};
    vecs[13] = '{1'b1, 1'b1, 2'd3, 32'h0000_1000, 32'hA5A5_0001, 32'h0};
    vecs[14] = '{1'b0, 1'b0, 2'd2, 32'h0000_0000, 32'h0,         32'hA5A5_0001};
    vecs[15] = '{1'b1, 1'b1, 2'd2, 32'h0000_0020, 32'h0102_0304, 32'h0};
    vecs[16] = '{1'b1, 1'b1, 2'd0, 32'h0000_0023, 32'h1234_5677, 32'h0};
    vecs[17] = '{1'b1, 1'b0, 2'd0, 32'h0000_0022, 32'h0,         32'h0000_0002};
    vecs[18] = '{1'b1, 1'b0, 2'd3, 32'h0000_0020, 32'h0,         32'h7702_0304};

    // Clock/reset
    reset = 1'b1;
    ifu_reqValid = 1'b0; ifu_addr = 32'h0;
    lsu_reqValid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0;
    lsu_size = 2'd0; lsu_wdata = 32'h0;
    repeat (2) @(negedge clock);
    check("reset resp", {lsu_respValid, ifu_respValid}, 2'b00);
    check("reset busy", busy, 1'b0);
    check("reset state", state_dbg, 2'd0);
    check("reset lsu_rdata", lsu_rdata, 32'h0);
    check("reset ifu_rdata", ifu_rdata, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) run_txn(vecs[i], i);

    // Both ports request together: lsu first, ifu on the next IDLE cycle.
    @(negedge clock);
    lsu_reqValid = 1'b1; lsu_wen = 1'b0; lsu_size = 2'd2; lsu_addr = 32'h10;
    ifu_reqValid = 1'b1; ifu_addr = 32'h20;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      if (c == 1) lsu_reqValid = 1'b0;
      if (c == 4) ifu_reqValid = 1'b0;
      check($sformatf("arb c%0d lsu_resp", c), lsu_respValid, (c == 2));
      check($sformatf("arb c%0d ifu_resp", c), ifu_respValid, (c == 5));
      check($sformatf("arb c%0d busy", c), busy, (c == 1 || c == 2 || c == 4 || c == 5));
      if (c == 2) check("arb lsu_rdata", lsu_rdata, 32'hBABE_AA44);
      if (c == 5) check("arb ifu_rdata", ifu_rdata, 32'h7702_0304);
    end

    // lsu request held through RESP: one pulse per accept, accepts 3 apart.
    @(negedge clock);
    lsu_reqValid = 1'b1; lsu_wen = 1'b0; lsu_size = 2'd1; lsu_addr = 32'h12;
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (c == 8) lsu_reqValid = 1'b0;
      check($sformatf("hold c%0d lsu_resp", c), lsu_respValid, (c == 2 || c == 5 || c == 8));
      if (lsu_respValid) begin
        pulses++;
        check($sformatf("hold c%0d lsu_rdata", c), lsu_rdata, 32'h0000_BABE);
      end
    end
    check("hold pulse count", pulses, 3);

    // Reset during WAIT of a store aborts it; accept right after reset.
    @(negedge clock);
    lsu_reqValid = 1'b1; lsu_wen = 1'b1; lsu_size = 2'd2;
    lsu_addr = 32'h20; lsu_wdata = 32'hFFFF_FFFF;
    @(negedge clock);
    lsu_reqValid = 1'b0;
    check("abort wait busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("abort async busy", busy, 1'b0);
    check("abort async lsu_rdata", lsu_rdata, 32'h0);
    @(negedge clock);
    check("abort no resp", {lsu_respValid, ifu_respValid}, 2'b00);
    reset = 1'b0;
    lsu_reqValid = 1'b1; lsu_wen = 1'b0; lsu_size = 2'd2; lsu_addr = 32'h20;
    @(negedge clock);
    lsu_reqValid = 1'b0;
    check("post-reset accept busy", busy, 1'b1);
    @(negedge clock);
    check("post-reset lsu_resp", lsu_respValid, 1'b1);
    check("abort word unchanged", lsu_rdata, 32'h7702_0304);
    @(negedge clock);
    check("post-reset pulse end", {lsu_respValid, busy}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
